// File: rtl/wb_multi_counter_pkg.sv
// Shared register map, bit positions and helpers
// for the Wishbone multi-channel counter.
package wb_multi_counter_pkg;

   typedef enum logic [1:0] {
      REG_COUNT   = 2'd0,
      REG_COMPARE = 2'd1,
      REG_CTRL    = 2'd2,
      REG_STATUS  = 2'd3
   } reg_e;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_DOWN    = 1;
   localparam int CTRL_ONESHOT = 2;
   localparam int CTRL_IRQ_EN  = 3;
   localparam int CTRL_W       = 4;

   localparam int STAT_MATCH = 0;

   localparam int CH_MSB  = 6;
   localparam int CH_LSB  = 4;
   localparam int REG_MSB = 3;
   localparam int REG_LSB = 2;

   function automatic logic [31:0] lane_merge(
      input logic [31:0] old_v,
      input logic [31:0] wr_v,
      input logic [3:0]  sel
   );
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = sel[b] ? wr_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_multi_counter_channel.sv
// One counter channel: COUNT, COMPARE, CTRL and
// sticky MATCH with its own update priority.
module counter_channel
   import wb_multi_counter_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_i,
   input  reg_e              reg_i,
   input  logic [31:0]       wdata_i,
   input  logic [3:0]        sel_i,
   input  logic              la_load_i,
   input  logic [BITS-1:0]   la_value_i,
   output logic [BITS-1:0]   count_o,
   output logic [BITS-1:0]   compare_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              match_o,
   output logic              irq_o
);

   localparam logic [BITS-1:0] ONE = BITS'(1);

   logic [BITS-1:0]   count_q, count_d;
   logic [BITS-1:0]   cmp_q, cmp_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              match_q, match_d;
   logic [BITS-1:0]   step_v;
   logic [31:0]       old_v, wm;
   logic              cnt_wr, cmp_wr, ctl_wr, st_wr;
   logic              step, hit;

   assign cnt_wr = wr_i && (reg_i == REG_COUNT);
   assign cmp_wr = wr_i && (reg_i == REG_COMPARE);
   assign ctl_wr = wr_i && (reg_i == REG_CTRL);
   assign st_wr  = wr_i && (reg_i == REG_STATUS);

   always_comb begin
      old_v = '0;
      unique case (reg_i)
         REG_COUNT:   old_v = 32'(count_q);
         REG_COMPARE: old_v = 32'(cmp_q);
         REG_CTRL:    old_v = 32'(ctrl_q);
         REG_STATUS:  old_v = 32'(match_q);
      endcase
   end

   assign wm = lane_merge(old_v, wdata_i, sel_i);

   // Only a real step may raise MATCH; loads never do.
   assign step_v = ctrl_q[CTRL_DOWN] ? count_q - ONE
                                     : count_q + ONE;
   assign step   = ctrl_q[CTRL_EN] && !cnt_wr && !la_load_i;
   assign hit    = step && (step_v == cmp_q);

   always_comb begin
      count_d = count_q;
      cmp_d   = cmp_q;
      ctrl_d  = ctrl_q;
      match_d = match_q;
      if (cnt_wr)         count_d = wm[BITS-1:0];
      else if (la_load_i) count_d = la_value_i;
      else if (step)      count_d = step_v;
      if (cmp_wr) cmp_d = wm[BITS-1:0];
      if (hit && ctrl_q[CTRL_ONESHOT]) ctrl_d[CTRL_EN] = 1'b0;
      if (ctl_wr) ctrl_d = wm[CTRL_W-1:0];
      if (st_wr && sel_i[0] && wdata_i[STAT_MATCH]) match_d = 1'b0;
      if (hit) match_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         cmp_q   <= '1;
         ctrl_q  <= '0;
         match_q <= 1'b0;
      end else begin
         count_q <= count_d;
         cmp_q   <= cmp_d;
         ctrl_q  <= ctrl_d;
         match_q <= match_d;
      end
   end

   if (BITS < 32) begin : g_pad
      logic unused_hi;
      assign unused_hi = ^wm[31:BITS];
   end

   assign count_o   = count_q;
   assign compare_o = cmp_q;
   assign ctrl_o    = ctrl_q;
   assign match_o   = match_q;
   assign irq_o     = match_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: rtl/wb_multi_counter.sv
// Wishbone slave front end: decode, single-cycle
// ack, registered read mux over the channels.
module wb_multi_counter
   import wb_multi_counter_pkg::*;
#(
   parameter int BITS     = 32,
   parameter int CHANNELS = 4
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   input  logic                     wbs_stb_i,
   input  logic                     wbs_cyc_i,
   input  logic                     wbs_we_i,
   input  logic [3:0]               wbs_sel_i,
   input  logic [31:0]              wbs_dat_i,
   input  logic [31:0]              wbs_adr_i,
   output logic                     wbs_ack_o,
   output logic [31:0]              wbs_dat_o,
   input  logic [CHANNELS-1:0]      la_load_i,
   input  logic [BITS-1:0]          la_value_i,
   output logic [CHANNELS*BITS-1:0] count_o,
   output logic [CHANNELS-1:0]      irq_o
);

   logic              ack_q, ack_d;
   logic [31:0]       dat_q, dat_d;
   logic [31:0]       rdata;
   logic              valid, wr;
   logic [2:0]        ch;
   reg_e              rsel;
   logic              unused_adr;

   logic [BITS-1:0]   cnt_a [CHANNELS];
   logic [BITS-1:0]   cmp_a [CHANNELS];
   logic [CTRL_W-1:0] ctl_a [CHANNELS];
   logic [CHANNELS-1:0] match_a;

   assign valid = wbs_cyc_i & wbs_stb_i;
   assign ch    = wbs_adr_i[CH_MSB:CH_LSB];
   assign rsel  = reg_e'(wbs_adr_i[REG_MSB:REG_LSB]);
   assign wr    = valid & ack_q & wbs_we_i;

   assign unused_adr = ^{wbs_adr_i[31:CH_MSB+1],
                         wbs_adr_i[REG_LSB-1:0]};

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      counter_channel #(.BITS(BITS)) u_ch (
         .clk_i      (wb_clk_i),
         .rst_i      (wb_rst_i),
         .wr_i       (wr && (ch == 3'(i))),
         .reg_i      (rsel),
         .wdata_i    (wbs_dat_i),
         .sel_i      (wbs_sel_i),
         .la_load_i  (la_load_i[i]),
         .la_value_i (la_value_i),
         .count_o    (cnt_a[i]),
         .compare_o  (cmp_a[i]),
         .ctrl_o     (ctl_a[i]),
         .match_o    (match_a[i]),
         .irq_o      (irq_o[i])
      );
      assign count_o[i*BITS +: BITS] = cnt_a[i];
   end

   // Channels beyond CHANNELS match no entry and read as zero.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (ch == 3'(i)) begin
            unique case (rsel)
               REG_COUNT:   rdata = 32'(cnt_a[i]);
               REG_COMPARE: rdata = 32'(cmp_a[i]);
               REG_CTRL:    rdata = 32'(ctl_a[i]);
               REG_STATUS:  rdata = 32'(match_a[i]);
            endcase
         end
      end
   end

   assign ack_d = valid & ~ack_q;
   assign dat_d = ack_d ? rdata : '0;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_multi_counter.sv
// Scoreboard bench for wb_multi_counter: a 32-bit
// 4-channel and an 8-bit 1-channel copy share one bus.
module tb_wb_multi_counter;

   localparam logic [1:0] R_CNT = 2'd0;
   localparam logic [1:0] R_CMP = 2'd1;
   localparam logic [1:0] R_CTL = 2'd2;
   localparam logic [1:0] R_STS = 2'd3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, stb, cyc, we;
   logic [3:0]   sel;
   logic [31:0]  dat_i, adr;
   logic         ack, ack8;
   logic [31:0]  dat_o, dat8;
   logic [3:0]   la_load;
   logic [31:0]  la_val;
   logic [0:0]   la_load8;
   logic [7:0]   la_val8;
   logic [127:0] cnt;
   logic [3:0]   irq;
   logic [7:0]   cnt8;
   logic [0:0]   irq8;
   logic [3:0]   la_ack_mask;

   wb_multi_counter #(.BITS(32), .CHANNELS(4)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
      .wbs_ack_o(ack), .wbs_dat_o(dat_o),
      .la_load_i(la_load), .la_value_i(la_val),
      .count_o(cnt), .irq_o(irq)
   );

   wb_multi_counter #(.BITS(8), .CHANNELS(1)) dut8 (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
      .wbs_ack_o(ack8), .wbs_dat_o(dat8),
      .la_load_i(la_load8), .la_value_i(la_val8),
      .count_o(cnt8), .irq_o(irq8)
   );

   typedef struct {
      string       nm;
      bit          chk;
      logic [31:0] exp;
      bit          chk8;
      logic [7:0]  exp8;
   } sb_t;

   sb_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h",
                  nm, act, exp);
      end
   endtask

   function automatic logic [31:0] cnt_ch(input int i);
      return cnt[i*32 +: 32];
   endfunction

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ack) begin
            if (sb.size() == 0) begin
               check("spurious_ack", 32'(ack), 32'd0);
            end else begin
               sb_t t;
               t = sb.pop_front();
               if (t.chk) check(t.nm, dat_o, t.exp);
               if (t.chk8)
                  check({t.nm, "_b8"}, dat8, 32'(t.exp8));
            end
         end
      end
   end

   task automatic xfer(input bit w, input logic [2:0] ch,
                       input logic [1:0] r,
                       input logic [31:0] d,
                       input logic [3:0] s,
                       input string nm,
                       input bit c, input logic [31:0] e,
                       input bit c8, input logic [7:0] e8);
      sb_t t;
      bit got;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w;
      adr = {25'd0, ch, r, 2'b00};
      dat_i = d; sel = s;
      t.nm = nm; t.chk = c; t.exp = e;
      t.chk8 = c8; t.exp8 = e8;
      sb.push_back(t);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(posedge clk);
         #1;
         got = ack;
      end
      if (!got) begin
         t = sb.pop_back();
         check({nm, "_ack"}, 32'd0, 32'd1);
      end
      la_load = la_ack_mask;
      @(posedge clk);
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      la_load = '0;
   endtask

   task automatic wr(input logic [2:0] ch,
                     input logic [1:0] r,
                     input logic [31:0] d);
      xfer(1'b1, ch, r, d, 4'hF, "wr", 1'b0, 32'd0, 1'b0, 8'd0);
   endtask

   task automatic rd(input string nm, input logic [2:0] ch,
                     input logic [1:0] r,
                     input logic [31:0] e,
                     input bit c8, input logic [7:0] e8);
      xfer(1'b0, ch, r, 32'd0, 4'hF, nm, 1'b1, e, c8, e8);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] up_exp [2];
      logic [7:0]  up8_exp [2];
      logic [31:0] dn_exp [4];
      logic [3:0]  dn_irq;
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
      sel = 4'h0; dat_i = '0; adr = '0;
      la_load = '0; la_val = '0;
      la_load8 = '0; la_val8 = '0;
      la_ack_mask = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_cnt_lo", cnt[31:0] | cnt[63:32], 32'd0);
      check("rst_cnt_hi", cnt[95:64] | cnt[127:96], 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_dat", dat_o, 32'd0);
      check("rst_cnt8", 32'(cnt8), 32'd0);
      rd("rst_cmp0", 3'd0, R_CMP, 32'hFFFF_FFFF, 1'b1, 8'hFF);
      rd("rst_ctl0", 3'd0, R_CTL, 32'd0, 1'b1, 8'h00);

      // ch1 free-running up count toward COMPARE=5
      wr(3'd1, R_CMP, 32'd5);
      wr(3'd1, R_CTL, 32'h1);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("up_cnt%0d", k), cnt_ch(1), 32'(k));
         check($sformatf("up_irq%0d", k), 32'(irq[1]), 32'd0);
      end
      wr(3'd1, R_CTL, 32'h0);
      rd("up_match", 3'd1, R_STS, 32'd1, 1'b0, 8'd0);
      xfer(1'b1, 3'd1, R_STS, 32'd1, 4'hF, "w1c_prewr",
           1'b1, 32'd1, 1'b0, 8'd0);
      rd("w1c_clr", 3'd1, R_STS, 32'd0, 1'b0, 8'd0);

      // ch0 oneshot down count to 0 with interrupt
      wr(3'd0, R_CNT, 32'd3);
      wr(3'd0, R_CMP, 32'd0);
      wr(3'd0, R_CTL, 32'hF);
      dn_exp[0] = 32'd2; dn_exp[1] = 32'd1;
      dn_exp[2] = 32'd0; dn_exp[3] = 32'd0;
      dn_irq = 4'b1100;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("dn_cnt%0d", k), cnt_ch(0), dn_exp[k]);
         check($sformatf("dn_irq%0d", k), 32'(irq[0]),
               32'(dn_irq[k]));
         check($sformatf("dn_cnt8_%0d", k), 32'(cnt8), dn_exp[k]);
      end
      rd("dn_ctl", 3'd0, R_CTL, 32'hE, 1'b1, 8'h0E);
      wr(3'd0, R_STS, 32'd1);
      check("dn_irq_clr", 32'(irq[0]), 32'd0);
      check("dn_irq8_clr", 32'(irq8), 32'd0);

      // 8-bit wrap past 0xFF with COMPARE=0x80
      wr(3'd0, R_CMP, 32'h80);
      wr(3'd0, R_CNT, 32'hFE);
      wr(3'd0, R_CTL, 32'h1);
      up_exp[0] = 32'hFF;  up_exp[1] = 32'h100;
      up8_exp[0] = 8'hFF;  up8_exp[1] = 8'h00;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("wrap8_%0d", k), 32'(cnt8),
               32'(up8_exp[k]));
         check($sformatf("wrap32_%0d", k), cnt_ch(0), up_exp[k]);
      end
      rd("wrap_nomatch", 3'd0, R_STS, 32'd0, 1'b1, 8'd0);
      wr(3'd0, R_CTL, 32'h0);

      // Wishbone COUNT write beats la_load
      la_val = 32'h20;
      la_ack_mask = 4'b0100;
      wr(3'd2, R_CNT, 32'h10);
      la_ack_mask = '0;
      check("prio_wb", cnt_ch(2), 32'h10);
      @(negedge clk);
      la_load = 4'b0100;
      @(posedge clk);
      #1;
      la_load = '0;
      check("prio_la", cnt_ch(2), 32'h20);
      check("prio_ch3", cnt_ch(3), 32'd0);

      // byte-lane write and out-of-range channels
      xfer(1'b1, 3'd3, R_CNT, 32'hAABB_CCDD, 4'h2, "lane",
           1'b0, 32'd0, 1'b0, 8'd0);
      rd("lane_rd", 3'd3, R_CNT, 32'h0000_CC00, 1'b0, 8'd0);
      check("lane_cnt", cnt_ch(3), 32'h0000_CC00);
      rd("ch7_rd", 3'd7, R_CNT, 32'd0, 1'b1, 8'd0);
      rd("ch1_cmp", 3'd1, R_CMP, 32'd5, 1'b1, 8'd0);

      // reset in the middle of a read and a running count
      wr(3'd1, R_CTL, 32'h1);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0;
      adr = {25'd0, 3'd1, R_CNT, 2'b00};
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("rst_noack%0d", k), 32'(ack), 32'd0);
      end
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++)
         check($sformatf("rst2_cnt%0d", i), cnt_ch(i), 32'd0);
      check("rst2_irq", 32'(irq), 32'd0);
      check("rst2_dat", dat_o, 32'd0);
      check("rst2_cnt8", 32'(cnt8), 32'd0);
      rd("rst2_cmp1", 3'd1, R_CMP, 32'hFFFF_FFFF, 1'b1, 8'd0);
      rd("rst2_cmp0", 3'd0, R_CMP, 32'hFFFF_FFFF, 1'b1, 8'hFF);
      rd("rst2_ctl1", 3'd1, R_CTL, 32'd0, 1'b0, 8'd0);

      repeat (3) @(negedge clk);
      if (sb.size() != 0)
         check("sb_left", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
